// File: rtl/pll_phase_ctrl_if.sv
// Request channel for pll_phase_ctrl: phase-shift target, direction and step count
// with a valid/ready handshake.
interface pll_phase_ctrl_if;
  logic       valid;
  logic       ready;
  logic [1:0] sel;
  logic       dir;
  logic [3:0] steps;

  modport master (output valid, output sel, output dir, output steps, input ready);
  modport slave  (input valid, input sel, input dir, input steps, output ready);
endinterface

// File: rtl/pll_phase_ctrl.sv
// ECP5 EHXPLLL dynamic phase-shift sequencer with PLL lock supervision.
// Define PLL_PHASE_TRACK_EN to add the per-output signed phase position tracker (phase_pos_o).
module pll_phase_ctrl #(
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned PULSE_CYC    = 4,
  parameter int unsigned GAP_CYC      = 8,
  parameter int unsigned LOCK_SETTLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65535,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clkin,
  input  logic             rst,
  pll_phase_ctrl_if.slave  req,
  input  logic             pll_lock_i,
  output logic [1:0]       phasesel_o,
  output logic             phasedir_o,
  output logic             phasestep_o,
  output logic             phaseloadreg_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
`ifdef PLL_PHASE_TRACK_EN
  ,
  output logic [31:0]      phase_pos_o
`endif
);

  typedef enum logic [2:0] {
    StIdle, StSetup, StPulse, StGap, StWaitLock, StDone, StErr
  } state_e;

  localparam logic [CNT_W-1:0] SetupLast   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PulseLast   = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GapLast     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] SettleTgt   = CNT_W'(LOCK_SETTLE);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             sync1_q, lock_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [3:0]       remaining_q, remaining_d;
  logic [1:0]       phasesel_q, phasesel_d;
  logic             phasedir_q, phasedir_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;
  logic             phasestep_q, ready_q, busy_q, done_q;
  logic             accept, in_seq;

  assign accept = req.valid & ready_q;
  assign in_seq = (state_q == StSetup) || (state_q == StPulse) || (state_q == StGap);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    settle_d    = settle_q;
    remaining_d = remaining_q;
    phasesel_d  = phasesel_q;
    phasedir_d  = phasedir_q;
    err_d       = err_q;
    abort_d     = abort_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          phasesel_d  = req.sel;
          phasedir_d  = req.dir;
          remaining_d = req.steps;
          err_d       = 1'b0;
          abort_d     = 1'b0;
          state_d     = (req.steps == 4'd0) ? StDone : StSetup;
        end
      end
      StSetup: begin
        if (cnt_q == SetupLast) begin
          state_d = StPulse;
          cnt_d   = '0;
        end
      end
      StPulse: begin
        if (cnt_q == PulseLast) begin
          state_d     = StGap;
          cnt_d       = '0;
          remaining_d = remaining_q - 4'd1;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d    = '0;
          settle_d = '0;
          state_d  = (remaining_q == 4'd0) ? StWaitLock : StPulse;
        end
      end
      StWaitLock: begin
        settle_d = lock_s_q ? settle_q + CNT_W'(1) : '0;
        // Settling wins over a timeout landing on the same cycle.
        if (lock_s_q && (settle_q + CNT_W'(1) == SettleTgt)) begin
          state_d = abort_q ? StErr : StDone;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StErr;
        end
      end
      StDone, StErr: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase

    // Lock loss while stepping discards the rest of the request and waits for relock.
    if (in_seq && !lock_s_q) begin
      state_d     = StWaitLock;
      cnt_d       = '0;
      settle_d    = '0;
      remaining_d = '0;
      abort_d     = 1'b1;
      err_d       = 1'b1;
    end

    if (state_d == StErr) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sync1_q     <= 1'b0;
      lock_s_q    <= 1'b0;
      cnt_q       <= '0;
      settle_q    <= '0;
      remaining_q <= '0;
      phasesel_q  <= '0;
      phasedir_q  <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      phasestep_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= pll_lock_i;
      lock_s_q    <= sync1_q;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      remaining_q <= remaining_d;
      phasesel_q  <= phasesel_d;
      phasedir_q  <= phasedir_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      phasestep_q <= (state_d == StPulse);
      // sync1_q is the next value of lock_s_q, so this equals (state==IDLE) & lock_s.
      ready_q     <= (state_d == StIdle) & sync1_q;
      busy_q      <= (state_d != StIdle);
      done_q      <= (state_d == StDone);
    end
  end

  assign req.ready      = ready_q;
  assign phasesel_o     = phasesel_q;
  assign phasedir_o     = phasedir_q;
  assign phasestep_o    = phasestep_q;
  assign phaseloadreg_o = 1'b0;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

`ifdef PLL_PHASE_TRACK_EN
  logic [31:0] pos_q, pos_d;
  logic        pulse_done;

  // A pulse counts only if it ran its full width without an abort.
  assign pulse_done = (state_q == StPulse) && lock_s_q && (cnt_q == PulseLast);

  always_comb begin
    pos_d = pos_q;
    for (int i = 0; i < 4; i++) begin
      if (pulse_done && (phasesel_q == 2'(i))) begin
        pos_d[i*8 +: 8] = pos_q[i*8 +: 8] + (phasedir_q ? 8'h01 : 8'hff);
      end
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign phase_pos_o = pos_q;
`endif

endmodule
